// File: rtl/oht_sram_debug_port_if.sv
// Signal bundle between the OHT entropy source, the debug controls and the SRAM write port.
// slave = oht_sram_debug_port; master = whatever drives the controls and observes the outputs.
interface oht_sram_debug_port_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) ();
    localparam int SEL_W = $clog2(WIDTH);

    logic             debug_i;
    logic [1:0]       mode_i;
    logic             start_i;
    logic [SEL_W-1:0] tap_sel_i;
    logic [WIDTH-1:0] oht_outputs_i;
    logic             oht_valid_i;
    logic             sram_mux_in_i;
    logic             oht_mux_out_o;
    logic [WIDTH-1:0] sram_in_o;
    logic             sram_we_o;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] drop_cnt_o;
    logic             parity_err_o;

    modport slave (
        input  debug_i, mode_i, start_i, tap_sel_i, oht_outputs_i, oht_valid_i, sram_mux_in_i,
        output oht_mux_out_o, sram_in_o, sram_we_o, busy_o, done_o, drop_cnt_o, parity_err_o
    );

    modport master (
        output debug_i, mode_i, start_i, tap_sel_i, oht_outputs_i, oht_valid_i, sram_mux_in_i,
        input  oht_mux_out_o, sram_in_o, sram_we_o, busy_o, done_o, drop_cnt_o, parity_err_o
    );
endinterface

// File: rtl/oht_sram_debug_port.sv
// Registered OHT -> SRAM debug port: passthrough, bit tap/override, serial word inject/capture.
// Optional OHT_SRAM_PARITY_EN adds a trailing even-parity bit to every serial frame.
//
// state     | meaning
// IDLE      | passthrough, or bit tap/override in mode 01
// SHIFT_IN  | sampling the serial inject frame, OHT words dropped
// INJECT    | writing the assembled word to the SRAM
// CAP_WAIT  | passthrough, waiting for a valid OHT word to capture
// SHIFT_OUT | serialising the captured frame, then pulsing done
module oht_sram_debug_port #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    oht_sram_debug_port_if.slave bus
);
    localparam int SEL_W = $clog2(WIDTH);
`ifdef OHT_SRAM_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME + 1);

    typedef enum logic [2:0] {IDLE, SHIFT_IN, INJECT, CAP_WAIT, SHIFT_OUT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [FRAME-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] sram_in_q, sram_in_d;
    logic             sram_we_q, sram_we_d;
    logic             mux_out_q, mux_out_d;
    logic             done_q, done_d;
    logic             perr_q, perr_d;
    logic [CNT_W-1:0] drop_q, drop_d, drop_inc;
    logic [WIDTH-1:0] inj_word, tap_word;
    logic             inj_par_ok, tap_bit;
    logic [FRAME-1:0] cap_frame;

`ifdef OHT_SRAM_PARITY_EN
    assign inj_word   = shreg_q[FRAME-1:1];
    assign inj_par_ok = ~^shreg_q;
    assign cap_frame  = {bus.oht_outputs_i, ^bus.oht_outputs_i};
`else
    assign inj_word   = shreg_q;
    assign inj_par_ok = 1'b1;
    assign cap_frame  = bus.oht_outputs_i;
`endif

    assign drop_inc = (drop_q == '1) ? drop_q : drop_q + 1'b1;

    // Loop compare instead of direct indexing so an out-of-range tap_sel simply matches nothing.
    always_comb begin
        tap_bit  = 1'b0;
        tap_word = bus.oht_outputs_i;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.tap_sel_i == SEL_W'(i)) begin
                tap_bit     = bus.oht_outputs_i[i];
                tap_word[i] = bus.sram_mux_in_i;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        sram_in_d = bus.oht_outputs_i;
        sram_we_d = bus.oht_valid_i;
        mux_out_d = 1'b0;
        done_d    = 1'b0;
        drop_d    = drop_q;
        perr_d    = perr_q;
        if (!bus.debug_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.mode_i == 2'b01) begin
                        sram_in_d = tap_word;
                        mux_out_d = tap_bit;
                    end
                    if (bus.start_i && bus.mode_i == 2'b10) begin
                        state_d = SHIFT_IN;
                        cnt_d   = CW'(FRAME);
                    end else if (bus.start_i && bus.mode_i == 2'b11) begin
                        state_d = CAP_WAIT;
                    end
                end
                SHIFT_IN: begin
                    sram_in_d = sram_in_q;
                    sram_we_d = 1'b0;
                    if (bus.oht_valid_i) drop_d = drop_inc;
                    shreg_d = {shreg_q[FRAME-2:0], bus.sram_mux_in_i};
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_d = INJECT;
                end
                INJECT: begin
                    if (bus.oht_valid_i) drop_d = drop_inc;
                    sram_we_d = inj_par_ok;
                    sram_in_d = inj_par_ok ? inj_word : sram_in_q;
                    done_d    = 1'b1;
                    perr_d    = perr_q | ~inj_par_ok;
                    shreg_d   = '0;
                    state_d   = IDLE;
                end
                CAP_WAIT: begin
                    if (bus.oht_valid_i) begin
                        shreg_d = cap_frame;
                        cnt_d   = CW'(FRAME);
                        state_d = SHIFT_OUT;
                    end
                end
                SHIFT_OUT: begin
                    if (cnt_q != '0) begin
                        mux_out_d = shreg_q[FRAME-1];
                        shreg_d   = {shreg_q[FRAME-2:0], 1'b0};
                        cnt_d     = cnt_q - 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            sram_in_q <= '0;
            sram_we_q <= 1'b0;
            mux_out_q <= 1'b0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            sram_in_q <= sram_in_d;
            sram_we_q <= sram_we_d;
            mux_out_q <= mux_out_d;
            done_q    <= done_d;
            perr_q    <= perr_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.sram_in_o     = sram_in_q;
    assign bus.sram_we_o     = sram_we_q;
    assign bus.oht_mux_out_o = mux_out_q;
    assign bus.done_o        = done_q;
    assign bus.busy_o        = (state_q != IDLE);
    assign bus.drop_cnt_o    = drop_q;
    assign bus.parity_err_o  = perr_q;
endmodule

// File: tb/tb_oht_sram_debug_port.sv
// Directed bench for oht_sram_debug_port: expectations queued at drive time, popped after each edge.
module tb_oht_sram_debug_port;
    localparam int WIDTH = 32;
    localparam int CNT_W = 8;
    localparam int DMAX  = (1 << CNT_W) - 1;
`ifdef OHT_SRAM_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    oht_sram_debug_port_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
    oht_sram_debug_port #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   drop_exp = 0;

    function automatic logic [FRAME-1:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef OHT_SRAM_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [63:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_underflow observed=%0h expected=queued_entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic expect_ctl(input string t, input logic we, input logic mux, input logic dn, input logic bsy);
        push({t, "_we"}, 64'(we));
        push({t, "_mux"}, 64'(mux));
        push({t, "_done"}, 64'(dn));
        push({t, "_busy"}, 64'(bsy));
    endtask

    task automatic check_ctl();
        pop_chk(64'(bus.sram_we_o));
        pop_chk(64'(bus.oht_mux_out_o));
        pop_chk(64'(bus.done_o));
        pop_chk(64'(bus.busy_o));
    endtask

    task automatic expect_out(input string t, input logic [WIDTH-1:0] din, input logic we,
                              input logic mux, input logic dn, input logic bsy);
        push({t, "_sram_in"}, 64'(din));
        expect_ctl(t, we, mux, dn, bsy);
    endtask

    task automatic check_out();
        pop_chk(64'(bus.sram_in_o));
        check_ctl();
    endtask

    task automatic bump_drop();
        drop_exp = (drop_exp < DMAX) ? drop_exp + 1 : DMAX;
    endtask

    task automatic do_inject(input logic [WIDTH-1:0] word, input logic [FRAME-1:0] fr,
                             input logic valid, input logic exp_we);
        bus.debug_i       = 1'b1;
        bus.mode_i        = 2'b10;
        bus.start_i       = 1'b1;
        bus.oht_valid_i   = valid;
        bus.oht_outputs_i = 32'h1234_5678;
        expect_out("inj_start", 32'h1234_5678, valid, 1'b0, 1'b0, 1'b1);
        tick();
        check_out();
        bus.mode_i = 2'b00;
        for (int i = 0; i < FRAME; i++) begin
            bus.start_i       = (i == 3);
            bus.sram_mux_in_i = fr[FRAME-1-i];
            bus.oht_outputs_i = WIDTH'(i * 32'h0101_0101);
            push("inj_blocked_we", 64'(0));
            push("inj_busy", 64'(1));
            push("inj_done_early", 64'(0));
            tick();
            pop_chk(64'(bus.sram_we_o));
            pop_chk(64'(bus.busy_o));
            pop_chk(64'(bus.done_o));
            if (valid) bump_drop();
        end
        bus.start_i = 1'b0;
        if (valid) bump_drop();
        if (exp_we) push("inj_word", 64'(word));
        push("inj_we", 64'(exp_we));
        push("inj_done", 64'(1));
        push("inj_busy_end", 64'(0));
        push("inj_drop", 64'(drop_exp));
        tick();
        if (exp_we) pop_chk(64'(bus.sram_in_o));
        pop_chk(64'(bus.sram_we_o));
        pop_chk(64'(bus.done_o));
        pop_chk(64'(bus.busy_o));
        pop_chk(64'(bus.drop_cnt_o));
        bus.oht_valid_i = 1'b0;
        expect_ctl("inj_after", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_ctl();
    endtask

    initial begin
        logic [FRAME-1:0] fr;
        bus.debug_i       = 1'b0;
        bus.mode_i        = 2'b00;
        bus.start_i       = 1'b0;
        bus.tap_sel_i     = '0;
        bus.oht_outputs_i = 32'hFFFF_FFFF;
        bus.oht_valid_i   = 1'b1;
        bus.sram_mux_in_i = 1'b1;

        // reset dominates active inputs
        rst_i = 1'b1;
        tick();
        expect_out("rst", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("rst_drop", 64'(0));
        push("rst_perr", 64'(0));
        tick();
        check_out();
        pop_chk(64'(bus.drop_cnt_o));
        pop_chk(64'(bus.parity_err_o));
        rst_i = 1'b0;

        // passthrough with debug off
        bus.oht_outputs_i = 32'hDEAD_BEEF;
        bus.oht_valid_i   = 1'b1;
        bus.sram_mux_in_i = 1'b1;
        expect_out("pass", 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_out();
        bus.oht_valid_i   = 1'b0;
        bus.oht_outputs_i = 32'h0BAD_F00D;
        expect_out("pass_novalid", 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_out();

        // bit tap / override
        bus.debug_i       = 1'b1;
        bus.mode_i        = 2'b01;
        bus.tap_sel_i     = 5'd5;
        bus.oht_outputs_i = 32'h0000_0020;
        bus.oht_valid_i   = 1'b1;
        bus.sram_mux_in_i = 1'b0;
        expect_out("tap5", 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_out();
        bus.tap_sel_i     = 5'd0;
        bus.oht_outputs_i = 32'hFFFF_0000;
        bus.sram_mux_in_i = 1'b1;
        expect_out("tap0", 32'hFFFF_0001, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_out();
        bus.tap_sel_i     = 5'd31;
        bus.oht_outputs_i = 32'h8000_0000;
        bus.sram_mux_in_i = 1'b0;
        expect_out("tap31", 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_out();

        // start with mode 01 / 00 is ignored
        bus.start_i = 1'b1;
        push("start_m01_busy", 64'(0));
        tick();
        pop_chk(64'(bus.busy_o));
        bus.mode_i = 2'b00;
        push("start_m00_busy", 64'(0));
        tick();
        pop_chk(64'(bus.busy_o));
        bus.start_i = 1'b0;

        // inject with OHT words arriving every cycle
        do_inject(32'hA5A5_A5A5, frame_of(32'hA5A5_A5A5), 1'b1, 1'b1);
        push("inj_perr", 64'(0));
        tick();
        pop_chk(64'(bus.parity_err_o));

        // capture
        bus.mode_i      = 2'b11;
        bus.start_i     = 1'b1;
        bus.oht_valid_i = 1'b0;
        expect_ctl("cap_start", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_ctl();
        bus.start_i = 1'b0;
        bus.mode_i  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            expect_ctl("cap_wait", 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            check_ctl();
        end
        bus.oht_valid_i   = 1'b1;
        bus.oht_outputs_i = 32'h8000_0001;
        expect_out("cap_latch", 32'h8000_0001, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check_out();
        bus.oht_valid_i   = 1'b0;
        bus.oht_outputs_i = 32'h0;
        fr = frame_of(32'h8000_0001);
        for (int k = 0; k < FRAME; k++) begin
            expect_ctl("cap_bit", 1'b0, fr[FRAME-1-k], 1'b0, 1'b1);
            tick();
            check_ctl();
        end
        expect_ctl("cap_done", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_ctl();
        expect_ctl("cap_after", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_ctl();

        // abort inject by dropping debug after 10 bits
        bus.debug_i     = 1'b1;
        bus.mode_i      = 2'b10;
        bus.start_i     = 1'b1;
        bus.oht_valid_i = 1'b0;
        tick();
        bus.start_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.sram_mux_in_i = i[0];
            tick();
        end
        bus.debug_i = 1'b0;
        expect_ctl("abort", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_ctl();
        for (int i = 0; i < 3; i++) begin
            expect_ctl("abort_quiet", 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            check_ctl();
        end
        do_inject(32'h0F0F_1234, frame_of(32'h0F0F_1234), 1'b0, 1'b1);

        // drop counter saturation
        for (int n = 0; n < 7; n++) begin
            do_inject(32'h3C00_0000 + 32'(n), frame_of(32'h3C00_0000 + 32'(n)), 1'b1, 1'b1);
        end

        // reset mid-sequence
        bus.mode_i      = 2'b10;
        bus.start_i     = 1'b1;
        bus.oht_valid_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        repeat (5) tick();
        rst_i = 1'b1;
        drop_exp = 0;
        expect_ctl("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        push("rst_mid_drop", 64'(0));
        tick();
        check_ctl();
        pop_chk(64'(bus.drop_cnt_o));
        rst_i = 1'b0;
        bus.oht_valid_i = 1'b0;

`ifdef OHT_SRAM_PARITY_EN
        fr = frame_of(32'h0000_0001);
        fr[0] = ~fr[0];
        do_inject(32'h0000_0001, fr, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push("perr_sticky", 64'(1));
            tick();
            pop_chk(64'(bus.parity_err_o));
        end
        rst_i = 1'b1;
        push("perr_rst", 64'(0));
        tick();
        pop_chk(64'(bus.parity_err_o));
        rst_i = 1'b0;
`endif

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/oht_sram_debug_port.md
# oht_sram_debug_port

Parametrised, registered debug port between the OHT entropy-source outputs and the SRAM write port. It succeeds the combinational single-bit tap/override mux and adds a single-cycle-latency registered datapath. It also adds full-word serial injection into the SRAM, full-word capture with serial shift-out, and a dropped-word counter. One instance sits in front of each SRAM (latch OHT and jitter OHT).

## Interface
- `WIDTH`, 32, bits per OHT word / SRAM word (≥2)
- `SEL_W`, `$clog2(WIDTH)`, derived; bit-select width, not overridden
- `CNT_W`, 8, width of dropped-word counter
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `debug`  in  1  debug enable; 0 = pure passthrough
- `mode`  in  2  00 pass, 01 bit tap/override, 10 word inject, 11 word capture
- `start`  in  1  one-cycle pulse launching inject/capture
- `tap_sel`  in  SEL_W  bit index for mode 01
- `oht_outputs`  in  WIDTH  entropy word
- `oht_valid`  in  1  `oht_outputs` valid this cycle
- `sram_mux_in`  in  1  serial debug input
- `oht_mux_out`  out  1  serial debug output
- `sram_in`  out  WIDTH  SRAM write data
- `sram_we`  out  1  SRAM write strobe
- `busy`  out  1  inject/capture sequence in progress
- `done`  out  1  one-cycle completion pulse
- `drop_cnt`  out  CNT_W  saturating count of entropy words blocked during inject
- `parity_err`  out  1  sticky serial parity error (macro only)

## Operation
- **Reset:** all outputs 0, FSM to IDLE, shift register 0, `drop_cnt` 0.
- **Passthrough** (`debug`=0, or mode 00 in IDLE):
  - `sram_in` <= `oht_outputs`; `sram_we` <= `oht_valid`.
  - `oht_mux_out` <= 0.
- **Mode 01** (IDLE only), registered passthrough with:
  - `oht_mux_out` <= `oht_outputs[tap_sel]`.
  - `sram_in[tap_sel]` <= `sram_mux_in`.
  - `tap_sel` ≥ WIDTH: no override; `oht_mux_out` = 0.
- **FSM states:** IDLE, SHIFT_IN, INJECT, CAP_WAIT, SHIFT_OUT.
- **IDLE:**
  - `start` & `debug` & mode=10 -> SHIFT_IN.
  - `start` & `debug` & mode=11 -> CAP_WAIT.
  - Mode is latched at `start`; later mode changes are ignored until IDLE.
- **SHIFT_IN:**
  - Samples `sram_mux_in` MSB-first on FRAME consecutive edges. FRAME = WIDTH, or WIDTH+1 with parity.
  - Then -> INJECT.
- **INJECT** (one cycle): `sram_in` = assembled word, `sram_we`=1, `done`=1, -> IDLE.
- **Word blocking:** while in SHIFT_IN/INJECT, passthrough is blocked (`sram_we` from OHT = 0). Each `oht_valid`=1 cycle increments `drop_cnt`, saturating at all-ones.
- **CAP_WAIT:**
  - Passthrough continues.
  - First cycle with `oht_valid`=1 latches `oht_outputs` -> SHIFT_OUT.
- **SHIFT_OUT:**
  - `oht_mux_out` drives latched word MSB-first, one bit per cycle for FRAME cycles.
  - Next cycle: `done`=1, `oht_mux_out`=0, -> IDLE.
- **`busy`:** 1 in every state except IDLE.
- **Boundary conditions:**
  - `start` while busy: ignored.
  - `debug` falling while busy: abort to IDLE next edge. No `sram_we` from the injected word, no `done`, shift register cleared.
  - `rst` mid-sequence: immediate return to reset values; `drop_cnt` cleared.
  - `start` with mode 00/01: ignored.

## Timing
- Passthrough and tap latency: 1 cycle, input edge N -> output valid after edge N.
- Inject: `start` at edge S. Bits are sampled at edges S+1..S+FRAME. `sram_we`/`done` are high in the cycle after edge S+FRAME+1.
- Capture: `oht_valid` latched at edge V. Bit k (MSB = k0) appears on `oht_mux_out` after edge V+1+k. `done` is high after edge V+FRAME+1.
- `done` and `sram_we` are always exactly one cycle wide.

## Configuration
- **`OHT_SRAM_PARITY_EN` defined:**
  - Serial frames carry a trailing even-parity bit (FRAME = WIDTH+1).
  - Shift-out appends parity after the LSB.
  - On inject, a parity mismatch suppresses `sram_we`, still pulses `done`, and sets `parity_err`. `parity_err` stays set until `rst`.
- **Undefined:** FRAME = WIDTH; no parity bit; `parity_err` tied 0.

## Test plan
- **Passthrough:** `debug`=0, `oht_outputs`=0xDEADBEEF with `oht_valid`=1 -> next cycle `sram_in`=0xDEADBEEF, `sram_we`=1, `oht_mux_out`=0.
- **Tap:** mode 01, `tap_sel`=5, `oht_outputs`=0x00000020, `sram_mux_in`=0 -> `oht_mux_out`=1, `sram_in`=0x00000000.
- **Inject:** mode 10, serial 0xA5A5A5A5 MSB-first while `oht_valid`=1 throughout -> `sram_in`=0xA5A5A5A5 with a one-cycle `sram_we`/`done`; `drop_cnt`=33 (WIDTH=32, no parity).
- **Capture:** mode 11, `oht_valid` pulse with 0x80000001 -> `oht_mux_out` sequence 1, 0×30, 1, then `done`.
- **Abort:** `debug` dropped after 10 inject bits -> `busy`=0 next cycle, no `sram_we`, no `done`. A new inject then completes correctly.
- **Parity (macro on):** inject 0x00000001 with parity bit 0 -> `sram_we` stays 0, `done`=1, `parity_err`=1 until `rst`.
